// File: rtl/veririsc_pkg.sv
// ---------------------------------------------------------------------------
// veririsc_pkg
//   Shared declarations for the VeriRISC codebase slice: default datapath
//   widths and the program-loader FSM state encoding.
// ---------------------------------------------------------------------------
package veririsc_pkg;

    localparam int unsigned LOADER_WIDTH  = 8;  // CPU/memory data width
    localparam int unsigned LOADER_AWIDTH = 5;  // memory address width

    // CHECK is only reachable when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_RUN   = 2'd3
    } loader_state_e;

endpackage : veririsc_pkg

// File: rtl/veririsc_prog_loader.sv
// ---------------------------------------------------------------------------
// veririsc_prog_loader
//   Boot stage for the VeriRISC CPU. Accepts a program image as a word
//   stream on a valid/ready interface, writes it into CPU memory and holds
//   the CPU in reset until the whole image has been written.
//
//   Configuration macro: LOADER_CHECKSUM_EN
//     defined   : an extra checksum word (sum of image words mod 2**WIDTH)
//                 follows the image; a mismatch sets the sticky err flag and
//                 returns to IDLE with the CPU kept in reset.
//     undefined : no CHECK state, err tied to 0.
//
//   Ports
//     clk, rst   : clock (rising edge), asynchronous active-high reset
//     start      : one-cycle pulse requesting a (re)load
//     in_valid / in_data / in_ready : image word stream
//     mem_wr / mem_addr / mem_data  : memory write port, one pulse per word
//     cpu_rst    : active-high CPU reset
//     cpu_halt   : CPU halt flag, status only
//     busy       : loading (LOAD or CHECK)
//     done       : image loaded and CPU released (RUN)
//     err        : sticky checksum mismatch
//   All outputs are registered.
// ---------------------------------------------------------------------------
module veririsc_prog_loader
    import veririsc_pkg::*;
#(
    parameter int unsigned WIDTH  = LOADER_WIDTH,
    parameter int unsigned AWIDTH = LOADER_AWIDTH,
    parameter int unsigned DEPTH  = (1 << AWIDTH)   // must be <= 2**AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_data,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [AWIDTH:0] LAST_IDX = (AWIDTH + 1)'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_wr_q, mem_wr_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_data_q, mem_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;

`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              err_q, err_d;
`endif

    // cpu_halt is informational only; it never steers the FSM.
    logic halt_unused;
    assign halt_unused = cpu_halt;

    // in_ready_q is the registered decode of LOAD/CHECK, so the handshake
    // uses exactly the value the upstream sees.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = cnt_q[AWIDTH-1:0];
                    mem_data_d = in_data;
                    cnt_d      = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = sum_q + in_data;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end
`endif
                end
            end

`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                // The checksum word is consumed but never written to memory.
                if (accept) begin
                    if (in_data == sum_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        busy_d     = in_ready_d;
        // Release the CPU only once RUN has already been held for a cycle:
        // the final mem_wr pulse occupies the first RUN cycle, so the CPU
        // leaves reset on the cycle after that write.
        done_d     = (state_q == ST_RUN) && (state_d == ST_RUN);
        cpu_rst_d  = !done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready = in_ready_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign cpu_rst  = cpu_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : veririsc_prog_loader

// File: tb/tb_veririsc_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_veririsc_prog_loader
//   Directed bench for veririsc_prog_loader. Drivers push expected memory
//   writes into a queue as words are handed over; a monitor pops and checks
//   them whenever mem_wr is seen. Honors LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_veririsc_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_rst;
    logic       cpu_halt = 1'b0;
    logic       busy;
    logic       done;
    logic       err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [12:0] exp_q[$];   // {addr, data}
    logic [12:0] mon_e;
    logic [4:0]  exp_addr = '0;

    veririsc_prog_loader #(.WIDTH(8), .AWIDTH(5), .DEPTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_rst  (cpu_rst),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected at %0t",
                         mem_addr, mem_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e[12:8]));
                check("wr_data", 32'(mem_data), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one word; handshake completes on the posedge after the
    // negedge where in_ready is seen high. Optional idle gap afterwards,
    // optionally with a start pulse in its first cycle.
    task automatic send_word(input logic [7:0] d, input bit wr, input int gap, input bit pulse);
        int unsigned t;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: in_ready stayed 0 for 50 cycles, needed 1");
            in_valid = 1'b0;
            return;
        end
        if (wr) begin
            exp_q.push_back({exp_addr, d});
            exp_addr++;
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = (g == 0) ? pulse : 1'b0;
            check("ready_in_gap", 32'(in_ready), 32'd1);
        end
    endtask

    // mode 0: data = index; mode 1: data = 0x01. gaps: 1 selects the gap
    // pattern (with start pulses when pulses=1). chk: checksum word sent when
    // LOADER_CHECKSUM_EN is defined (-1 = correct sum).
    // Returns at the negedge just after the final handshake, with in_valid low.
    task automatic send_image(input int mode, input bit gaps, input bit pulses, input int chk);
        logic [7:0] d;
        logic [7:0] sum;
        int         gp;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            d   = (mode == 0) ? 8'(i) : 8'h01;
            sum = sum + d;
            gp  = 0;
            if (gaps && i != 31) gp = (i % 3 == 1) ? 1 : ((i % 5 == 0) ? 2 : 0);
            send_word(d, 1'b1, gp, pulses && (gp != 0));
        end
`ifdef LOADER_CHECKSUM_EN
        send_word((chk < 0) ? sum : 8'(chk), 1'b0, 0, 1'b0);
`else
        if (chk > 255) $display("note: checksum argument ignored");
`endif
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Post-load timing: at the negedge after the final handshake the CPU is
    // still in reset; one cycle later it is released and done is high.
    task automatic check_release(input string tag);
        check({tag, "_rst_held"}, 32'(cpu_rst), 32'd1);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_ready_dropped"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_rst_released"}, 32'(cpu_rst), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_not_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Test 1: reset, no stimulus
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
            check("idle_in_ready", 32'(in_ready), 32'd0);
            check("idle_mem_wr", 32'(mem_wr), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
        check("idle_err", 32'(err), 32'd0);
        check("idle_addr", 32'(mem_addr), 32'd0);

        // Test 2: back-to-back image 0x00..0x1F
        exp_addr = '0;
        pulse_start();
        check("load_busy", 32'(busy), 32'd1);
        check("load_ready", 32'(in_ready), 32'd1);
        check("load_cpu_rst", 32'(cpu_rst), 32'd1);
        send_image(0, 1'b0, 1'b0, -1);
`ifndef LOADER_CHECKSUM_EN
        check("last_write_visible", 32'(mem_wr), 32'd1);
        check("last_write_addr", 32'(mem_addr), 32'd31);
`endif
        check_release("b2b");

        // Test 3: reload from RUN with idle gaps
        exp_addr = '0;
        pulse_start();
        send_image(0, 1'b1, 1'b0, -1);
        check_release("gaps");

        // Test 4: async reset after 10 words, then full reload
        exp_addr = '0;
        pulse_start();
        for (int i = 0; i < 10; i++) send_word(8'(8'hA0 + i), 1'b1, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_mem_wr", 32'(mem_wr), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_data", 32'(mem_data), 32'd0);
        check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_arst_cpu_rst", 32'(cpu_rst), 32'd1);
        exp_addr = '0;
        pulse_start();
        send_image(0, 1'b0, 1'b0, -1);
        check_release("after_arst");

        // Test 5: start in RUN, then start pulses during LOAD are ignored
        exp_addr = '0;
        pulse_start();
        check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        send_image(0, 1'b1, 1'b1, -1);
        check_release("start_in_load");

`ifdef LOADER_CHECKSUM_EN
        // Test 6: checksum match and mismatch
        exp_addr = '0;
        pulse_start();
        send_image(1, 1'b0, 1'b0, 8'h20);
        check_release("chk_ok");
        check("chk_ok_err", 32'(err), 32'd0);
        exp_addr = '0;
        pulse_start();
        send_image(1, 1'b0, 1'b0, 8'h21);
        check("chk_bad_err", 32'(err), 32'd1);
        check("chk_bad_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("chk_bad_err_sticky", 32'(err), 32'd1);
        check("chk_bad_cpu_rst", 32'(cpu_rst), 32'd1);
        check("chk_bad_done", 32'(done), 32'd0);
        check("chk_bad_ready", 32'(in_ready), 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_veririsc_prog_loader
